// File: rtl/proc_mem_port_arbiter.sv
// Shared memory port arbiter: merges imem/dmem request streams onto one
// port (round-robin) and steers in-order responses back via a tag FIFO.
//
// Ports:
//   clk, reset (async, active-low)
//   imemreq_*/dmemreq_*   : processor request streams (val/rdy)
//   imemresp_*/dmemresp_* : processor response streams (val/rdy)
//   memreq_*/memresp_*    : shared memory request/response streams
//   num_outstanding       : registered in-flight request count
module proc_mem_port_arbiter #(
    parameter int p_max_outstanding = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [76:0] imemreq_msg,
    input  logic        imemreq_val,
    output logic        imemreq_rdy,

    output logic [46:0] imemresp_msg,
    output logic        imemresp_val,
    input  logic        imemresp_rdy,

    input  logic [76:0] dmemreq_msg,
    input  logic        dmemreq_val,
    output logic        dmemreq_rdy,

    output logic [46:0] dmemresp_msg,
    output logic        dmemresp_val,
    input  logic        dmemresp_rdy,

    output logic [76:0] memreq_msg,
    output logic        memreq_val,
    input  logic        memreq_rdy,

    input  logic [46:0] memresp_msg,
    input  logic        memresp_val,
    output logic        memresp_rdy,

    output logic [$clog2(p_max_outstanding+1)-1:0] num_outstanding
);

    localparam int CW = $clog2(p_max_outstanding + 1);
    localparam int PW = $clog2(p_max_outstanding);

    // prio: 0 = imem first, 1 = dmem first
    logic                         prio;
    // tag per in-flight request: 0 = imem, 1 = dmem
    logic [p_max_outstanding-1:0] tags;
    logic [PW-1:0]                head;
    logic [PW-1:0]                tail;
    logic [CW-1:0]                count;

    logic full;
    logic nonempty;
    logic can_issue;
    logic win;
    logic head_id;
    logic push;
    logic pop;

    assign full      = (count == CW'(p_max_outstanding));
    assign nonempty  = (count != '0);
    assign can_issue = memreq_rdy & ~full;

    // win = 1 selects dmem; imem is the default when nobody is valid
    assign win = (imemreq_val & dmemreq_val) ? prio : dmemreq_val;

    assign memreq_val  = reset & (imemreq_val | dmemreq_val);
    assign memreq_msg  = win ? dmemreq_msg : imemreq_msg;
    assign imemreq_rdy = reset & can_issue & ~win;
    assign dmemreq_rdy = reset & can_issue & win;

    assign push = memreq_val & can_issue;

    assign head_id = tags[head];

    // Only the port at the FIFO head may see a response
    assign imemresp_val = reset & nonempty & ~head_id & memresp_val;
    assign dmemresp_val = reset & nonempty & head_id & memresp_val;
    assign memresp_rdy  = reset & nonempty &
                          (head_id ? dmemresp_rdy : imemresp_rdy);
    assign imemresp_msg = memresp_msg;
    assign dmemresp_msg = memresp_msg;

    assign pop = memresp_val & memresp_rdy;

    assign num_outstanding = count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio  <= 1'b0;
            tags  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tags[tail] <= win;
                tail       <= tail + PW'(1);
                prio       <= ~win;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_mem_port_arbiter.sv
// Randomized bench for proc_mem_port_arbiter against a queue-based
// reference model of in-flight requests and round-robin preference.
module tb_proc_mem_port_arbiter;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [76:0] imemreq_msg = '0;
    logic        imemreq_val = 1'b0;
    logic        imemreq_rdy;
    logic [46:0] imemresp_msg;
    logic        imemresp_val;
    logic        imemresp_rdy = 1'b0;
    logic [76:0] dmemreq_msg = '0;
    logic        dmemreq_val = 1'b0;
    logic        dmemreq_rdy;
    logic [46:0] dmemresp_msg;
    logic        dmemresp_val;
    logic        dmemresp_rdy = 1'b0;
    logic [76:0] memreq_msg;
    logic        memreq_val;
    logic        memreq_rdy = 1'b0;
    logic [46:0] memresp_msg = '0;
    logic        memresp_val = 1'b0;
    logic        memresp_rdy;
    logic [2:0]  num_outstanding;

    proc_mem_port_arbiter #(.p_max_outstanding(P)) dut (
        .clk             (clk),
        .reset           (reset),
        .imemreq_msg     (imemreq_msg),
        .imemreq_val     (imemreq_val),
        .imemreq_rdy     (imemreq_rdy),
        .imemresp_msg    (imemresp_msg),
        .imemresp_val    (imemresp_val),
        .imemresp_rdy    (imemresp_rdy),
        .dmemreq_msg     (dmemreq_msg),
        .dmemreq_val     (dmemreq_val),
        .dmemreq_rdy     (dmemreq_rdy),
        .dmemresp_msg    (dmemresp_msg),
        .dmemresp_val    (dmemresp_val),
        .dmemresp_rdy    (dmemresp_rdy),
        .memreq_msg      (memreq_msg),
        .memreq_val      (memreq_val),
        .memreq_rdy      (memreq_rdy),
        .memresp_msg     (memresp_msg),
        .memresp_val     (memresp_val),
        .memresp_rdy     (memresp_rdy),
        .num_outstanding (num_outstanding)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // in-flight requests in issue order: 0 = imem, 1 = dmem
    bit q[$];
    // port preferred when both request: 0 = imem
    bit pref = 1'b0;

    task automatic chk(input string tag, input logic [76:0] got,
                       input logic [76:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_imemreq_rdy", 77'(imemreq_rdy), 77'(0));
        chk("rst_dmemreq_rdy", 77'(dmemreq_rdy), 77'(0));
        chk("rst_memreq_val", 77'(memreq_val), 77'(0));
        chk("rst_memresp_rdy", 77'(memresp_rdy), 77'(0));
        chk("rst_imemresp_val", 77'(imemresp_val), 77'(0));
        chk("rst_dmemresp_val", 77'(dmemresp_val), 77'(0));
        chk("rst_num_out", 77'(num_outstanding), 77'(0));
    endtask

    function automatic logic [76:0] rnd77();
        return 77'({$urandom(), $urandom(), $urandom()});
    endfunction

    // resp_pct: chance the memory offers a response this cycle
    task automatic drive_random(input int resp_pct, input int rdy_pct);
        imemreq_val  = ($urandom_range(0, 99) < 60);
        dmemreq_val  = ($urandom_range(0, 99) < 60);
        imemreq_msg  = rnd77();
        dmemreq_msg  = rnd77();
        memreq_rdy   = ($urandom_range(0, 99) < 80);
        memresp_val  = ($urandom_range(0, 99) < resp_pct);
        memresp_msg  = 47'(rnd77());
        imemresp_rdy = ($urandom_range(0, 99) < rdy_pct);
        dmemresp_rdy = ($urandom_range(0, 99) < rdy_pct);
    endtask

    // Check combinational outputs against the model, then advance a clock.
    task automatic step();
        int  n;
        bit  any;
        bit  w;
        bit  grant;
        bit  h;
        bit  take;
        n     = q.size();
        any   = imemreq_val | dmemreq_val;
        if (imemreq_val && dmemreq_val) w = pref;
        else w = dmemreq_val;
        grant = any && memreq_rdy && (n < P);

        chk("num_out", 77'(num_outstanding), 77'(n));
        chk("memreq_val", 77'(memreq_val), 77'(any));
        chk("memreq_msg", memreq_msg, w ? dmemreq_msg : imemreq_msg);
        if (imemreq_val)
            chk("imemreq_rdy", 77'(imemreq_rdy),
                77'(!w && memreq_rdy && n < P));
        if (dmemreq_val)
            chk("dmemreq_rdy", 77'(dmemreq_rdy),
                77'(w && memreq_rdy && n < P));
        chk("imemresp_msg", 77'(imemresp_msg), 77'(memresp_msg));
        chk("dmemresp_msg", 77'(dmemresp_msg), 77'(memresp_msg));

        take = 1'b0;
        if (n == 0) begin
            chk("empty_memresp_rdy", 77'(memresp_rdy), 77'(0));
            chk("empty_imemresp_val", 77'(imemresp_val), 77'(0));
            chk("empty_dmemresp_val", 77'(dmemresp_val), 77'(0));
        end else begin
            h = q[0];
            chk("imemresp_val", 77'(imemresp_val),
                77'(memresp_val && !h));
            chk("dmemresp_val", 77'(dmemresp_val),
                77'(memresp_val && h));
            chk("memresp_rdy", 77'(memresp_rdy),
                77'(h ? dmemresp_rdy : imemresp_rdy));
            take = memresp_val && (h ? dmemresp_rdy : imemresp_rdy);
        end

        @(posedge clk);
        if (take) void'(q.pop_front());
        if (grant) begin
            q.push_back(w);
            pref = !w;
        end
    endtask

    initial begin
        // reset held low with activity on every input
        imemreq_val = 1'b1;
        dmemreq_val = 1'b1;
        memreq_rdy  = 1'b1;
        memresp_val = 1'b1;
        imemresp_rdy = 1'b1;
        dmemresp_rdy = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // first transaction: lone imem read, then its response
        imemreq_val = 1'b1;
        imemreq_msg = 77'h200 << 32;
        dmemreq_val = 1'b0;
        memreq_rdy  = 1'b1;
        memresp_val = 1'b0;
        #1;
        step();
        @(negedge clk);
        imemreq_val = 1'b0;
        memresp_val = 1'b1;
        memresp_msg = 47'hCAFE;
        imemresp_rdy = 1'b1;
        #1;
        step();

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            case ((c / 400) % 4)
                0: drive_random(70, 80);
                1: drive_random(10, 80);
                2: drive_random(80, 30);
                default: drive_random(50, 60);
            endcase
            if (c == 2000 || c == 3100) begin
                // mid-operation reset with both requesters valid
                imemreq_val = 1'b1;
                dmemreq_val = 1'b1;
                memreq_rdy  = 1'b1;
                memresp_val = 1'b1;
                #1;
                reset = 1'b0;
                #1;
                chk_reset_outputs();
                q.delete();
                pref = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                // first grant after release goes to imem
                #1;
                chk("post_rst_imem_rdy", 77'(imemreq_rdy), 77'(1));
                chk("post_rst_dmem_rdy", 77'(dmemreq_rdy), 77'(0));
            end
            #1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
